// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Turns symbolic instruction commands (mnemonic code plus register and
//   immediate fields) into 32-bit MIPS words. The words are written to
//   instruction memory one after another, starting at BASE_ADDR.
//
//   Ports:
//     clk, reset_n            clock; synchronous active-low reset
//     start                   1-cycle pulse that begins a program (IDLE only)
//     cmd_valid / cmd_ready   command handshake
//     cmd_op                  0 nop, 1 addu, 2 subu, 3 ori, 4 lui, 5 lw,
//                             6 sw, 7 beq, 8 jal, 9 jr; 10-15 are illegal
//     cmd_rs/rt/rd/imm/target instruction fields
//     cmd_last                marks the final command of the program
//     im_we/im_addr/im_wdata  instruction memory write port
//     word_count              number of words written in this program
//     done                    1-cycle pulse when the program load finishes
//     err                     sticky flag: an illegal op was seen since start
//     full                    DEPTH words have been written
module instr_encoder_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int unsigned DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [4:0]  cmd_rs,
  input  logic [4:0]  cmd_rt,
  input  logic [4:0]  cmd_rd,
  input  logic [15:0] cmd_imm,
  input  logic [25:0] cmd_target,
  input  logic        cmd_last,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic [10:0] word_count,
  output logic        done,
  output logic        err,
  output logic        full
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [10:0] DEPTH_W = 11'(DEPTH);

  state_t      state;
  logic        last_accepted;
  logic [31:0] nxt_addr;
  logic        accept;
  logic        legal;
  logic [31:0] enc;

  // last_accepted blocks further commands in the cycle that the final write
  // is visible. The FSM then leaves RUN one cycle later, so done follows
  // that write.
  assign cmd_ready = (state == RUN) & ~full & ~last_accepted;
  assign accept    = cmd_valid & cmd_ready;

  always_comb begin
    enc   = '0;
    legal = 1'b1;
    unique case (cmd_op)
      4'd0: enc = '0;
      4'd1: enc = {6'h00, cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'h21};
      4'd2: enc = {6'h00, cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'h23};
      4'd3: enc = {6'h0d, cmd_rs, cmd_rt, cmd_imm};
      4'd4: enc = {6'h0f, 5'd0,   cmd_rt, cmd_imm};
      4'd5: enc = {6'h23, cmd_rs, cmd_rt, cmd_imm};
      4'd6: enc = {6'h2b, cmd_rs, cmd_rt, cmd_imm};
      4'd7: enc = {6'h04, cmd_rs, cmd_rt, cmd_imm};
      4'd8: enc = {6'h03, cmd_target};
      4'd9: enc = {6'h00, cmd_rs, 15'd0, 6'h08};
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      im_we         <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      full          <= 1'b0;
      im_addr       <= BASE_ADDR;
      nxt_addr      <= BASE_ADDR;
      im_wdata      <= '0;
      word_count    <= '0;
      last_accepted <= 1'b0;
    end else begin
      im_we <= 1'b0;
      done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state         <= RUN;
            err           <= 1'b0;
            full          <= 1'b0;
            word_count    <= '0;
            im_addr       <= BASE_ADDR;
            nxt_addr      <= BASE_ADDR;
            last_accepted <= 1'b0;
          end
        end
        RUN: begin
          if (last_accepted || full) begin
            state <= FIN;
            done  <= 1'b1;
          end else if (accept) begin
            if (cmd_last) last_accepted <= 1'b1;
            if (legal) begin
              im_we    <= 1'b1;
              im_addr  <= nxt_addr;
              im_wdata <= enc;
              nxt_addr <= nxt_addr + 32'd4;
              if (word_count != DEPTH_W) begin
                word_count <= word_count + 11'd1;
                if (word_count + 11'd1 == DEPTH_W) full <= 1'b1;
              end
            end else begin
              err <= 1'b1;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, start4 = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [3:0]  cmd_op = '0;
  logic [4:0]  cmd_rs = '0, cmd_rt = '0, cmd_rd = '0;
  logic [15:0] cmd_imm = '0;
  logic [25:0] cmd_target = '0;
  logic        cmd_last = 1'b0;

  logic        cmd_ready, im_we, done, err, full;
  logic [31:0] im_addr, im_wdata;
  logic [10:0] word_count;
  logic        cmd_ready4, im_we4, done4, err4, full4;
  logic [31:0] im_addr4, im_wdata4;
  logic [10:0] word_count4;

  instr_encoder_loader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
    .cmd_rd(cmd_rd), .cmd_imm(cmd_imm), .cmd_target(cmd_target),
    .cmd_last(cmd_last), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .word_count(word_count), .done(done), .err(err), .full(full)
  );

  instr_encoder_loader #(.DEPTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready4), .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
    .cmd_rd(cmd_rd), .cmd_imm(cmd_imm), .cmd_target(cmd_target),
    .cmd_last(cmd_last), .im_we(im_we4), .im_addr(im_addr4), .im_wdata(im_wdata4),
    .word_count(word_count4), .done(done4), .err(err4), .full(full4)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // write/done recorder
  int          nw = 0, nw4 = 0, done_cnt = 0, done_cnt4 = 0, done_cyc = 0;
  logic [31:0] wa [16];
  logic [31:0] wd [16];
  int          wc [16];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (im_we) begin
      if (nw < 16) begin
        wa[nw] = im_addr;
        wd[nw] = im_wdata;
        wc[nw] = cyc;
      end
      nw++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (im_we4) nw4++;
    if (done4) done_cnt4++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input bit to4);
    if (to4) start4 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start4 = 1'b0;
  endtask

  // Offers one command for up to 8 cycles; checks whether it was taken.
  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                      input logic last, input bit to4, input bit want, input string nm);
    bit ok;
    bit r;
    ok = 1'b0;
    cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
    cmd_imm = imm; cmd_target = tgt; cmd_last = last;
    cmd_valid = 1'b1;
    for (int i = 0; i < 8 && !ok; i++) begin
      #1;
      r = to4 ? cmd_ready4 : cmd_ready;
      @(negedge clk);
      ok = r;
    end
    cmd_valid = 1'b0;
    total++;
    if (ok !== want) begin
      bad++;
      $display("FAIL %s accepted got=%0b want=%0b", nm, ok, want);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    wait_cycles(2);
    total += 8;
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset cmd_ready got=%0b want=0", cmd_ready); end
    if (im_we !== 1'b0) begin bad++; $display("FAIL reset im_we got=%0b want=0", im_we); end
    if (done !== 1'b0) begin bad++; $display("FAIL reset done got=%0b want=0", done); end
    if (err !== 1'b0) begin bad++; $display("FAIL reset err got=%0b want=0", err); end
    if (full !== 1'b0) begin bad++; $display("FAIL reset full got=%0b want=0", full); end
    if (im_addr !== 32'h0000_3000) begin bad++; $display("FAIL reset im_addr got=%h want=00003000", im_addr); end
    if (im_wdata !== 32'h0) begin bad++; $display("FAIL reset im_wdata got=%h want=0", im_wdata); end
    if (word_count !== 11'd0) begin bad++; $display("FAIL reset word_count got=%0d want=0", word_count); end
    reset_n = 1'b1;
    wait_cycles(1);
  endtask

  task automatic test_basic;
    pulse_start(0);
    nw = 0; done_cnt = 0;
    send(4'd1, 5'd1, 5'd2, 5'd3, 16'hbeef, 26'h3ff_ffff, 1'b0, 0, 1, "basic_addu");
    send(4'd3, 5'd0, 5'd4, 5'd7, 16'h00ff, 26'h155_5555, 1'b1, 0, 1, "basic_ori");
    wait_cycles(4);
    total += 8;
    if (nw !== 2) begin bad++; $display("FAIL basic_writes got=%0d want=2", nw); end
    if (wa[0] !== 32'h3000) begin bad++; $display("FAIL basic_addr0 got=%h want=00003000", wa[0]); end
    if (wd[0] !== 32'h0022_1821) begin bad++; $display("FAIL basic_data0 got=%h want=00221821", wd[0]); end
    if (wa[1] !== 32'h3004) begin bad++; $display("FAIL basic_addr1 got=%h want=00003004", wa[1]); end
    if (wd[1] !== 32'h3404_00ff) begin bad++; $display("FAIL basic_data1 got=%h want=340400ff", wd[1]); end
    if (word_count !== 11'd2) begin bad++; $display("FAIL basic_word_count got=%0d want=2", word_count); end
    if (done_cnt !== 1) begin bad++; $display("FAIL basic_done_pulses got=%0d want=1", done_cnt); end
    if (done_cyc !== wc[1] + 1) begin bad++; $display("FAIL basic_done_timing got=%0d want=%0d", done_cyc, wc[1] + 1); end
  endtask

  task automatic test_back_to_back;
    pulse_start(0);
    nw = 0; done_cnt = 0;
    send(4'd4, 5'd9, 5'd5, 5'd9, 16'h1234, 26'h0, 1'b0, 0, 1, "b2b_lui");
    send(4'd8, 5'd1, 5'd1, 5'd1, 16'hffff, 26'h000_0c03, 1'b0, 0, 1, "b2b_jal");
    send(4'd9, 5'd31, 5'd3, 5'd4, 16'hffff, 26'h3ff_ffff, 1'b1, 0, 1, "b2b_jr");
    wait_cycles(4);
    total += 7;
    if (nw !== 3) begin bad++; $display("FAIL b2b_writes got=%0d want=3", nw); end
    if (wd[0] !== 32'h3c05_1234) begin bad++; $display("FAIL b2b_lui_data got=%h want=3c051234", wd[0]); end
    if (wd[1] !== 32'h0c00_0c03) begin bad++; $display("FAIL b2b_jal_data got=%h want=0c000c03", wd[1]); end
    if (wd[2] !== 32'h03e0_0008) begin bad++; $display("FAIL b2b_jr_data got=%h want=03e00008", wd[2]); end
    if (wa[2] !== 32'h3008) begin bad++; $display("FAIL b2b_addr2 got=%h want=00003008", wa[2]); end
    if (wc[2] - wc[0] !== 2) begin bad++; $display("FAIL b2b_one_per_cycle got=%0d want=2", wc[2] - wc[0]); end
    if (done_cnt !== 1) begin bad++; $display("FAIL b2b_done_pulses got=%0d want=1", done_cnt); end
  endtask

  task automatic test_illegal;
    pulse_start(0);
    nw = 0; done_cnt = 0;
    send(4'd0, 5'd7, 5'd7, 5'd7, 16'h7777, 26'h123_4567, 1'b0, 0, 1, "ill_nop0");
    send(4'd12, 5'd1, 5'd2, 5'd3, 16'h4444, 26'h0, 1'b0, 0, 1, "ill_op12");
    send(4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1, 0, 1, "ill_nop1");
    wait_cycles(4);
    total += 7;
    if (nw !== 2) begin bad++; $display("FAIL ill_writes got=%0d want=2", nw); end
    if (wa[1] !== 32'h3004) begin bad++; $display("FAIL ill_addr1 got=%h want=00003004", wa[1]); end
    if (wd[0] !== 32'h0) begin bad++; $display("FAIL ill_nop_data got=%h want=0", wd[0]); end
    if (err !== 1'b1) begin bad++; $display("FAIL ill_err got=%0b want=1", err); end
    if (word_count !== 11'd2) begin bad++; $display("FAIL ill_word_count got=%0d want=2", word_count); end
    if (done_cnt !== 1) begin bad++; $display("FAIL ill_done_pulses got=%0d want=1", done_cnt); end
    pulse_start(0);
    if (err !== 1'b0) begin bad++; $display("FAIL ill_err_cleared got=%0b want=0", err); end
    // illegal op carrying cmd_last still ends the program
    done_cnt = 0; nw = 0;
    send(4'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1, 0, 1, "ill_last");
    wait_cycles(4);
    total += 3;
    if (done_cnt !== 1) begin bad++; $display("FAIL ill_last_done got=%0d want=1", done_cnt); end
    if (nw !== 0) begin bad++; $display("FAIL ill_last_writes got=%0d want=0", nw); end
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL ill_last_idle_ready got=%0b want=0", cmd_ready); end
  endtask

  task automatic test_full;
    pulse_start(1);
    nw4 = 0; done_cnt4 = 0;
    for (int k = 0; k < 4; k++)
      send(4'd2, 5'(k), 5'd1, 5'd2, 16'h0, 26'h0, 1'b0, 1, 1, "full_accept");
    send(4'd2, 5'd5, 5'd1, 5'd2, 16'h0, 26'h0, 1'b0, 1, 0, "full_stall5");
    send(4'd2, 5'd6, 5'd1, 5'd2, 16'h0, 26'h0, 1'b0, 1, 0, "full_stall6");
    total += 5;
    if (nw4 !== 4) begin bad++; $display("FAIL full_writes got=%0d want=4", nw4); end
    if (full4 !== 1'b1) begin bad++; $display("FAIL full_flag got=%0b want=1", full4); end
    if (cmd_ready4 !== 1'b0) begin bad++; $display("FAIL full_ready got=%0b want=0", cmd_ready4); end
    if (word_count4 !== 11'd4) begin bad++; $display("FAIL full_word_count got=%0d want=4", word_count4); end
    if (done_cnt4 !== 1) begin bad++; $display("FAIL full_done_pulses got=%0d want=1", done_cnt4); end
  endtask

  task automatic test_random_valid;
    pulse_start(0);
    nw = 0; done_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      wait_cycles($urandom_range(0, 2));
      send(4'd6, 5'd29, 5'd8, 5'd17, 16'hfffc, 26'h2aa_aaaa, k == 3, 0, 1, "rnd_sw");
    end
    wait_cycles(4);
    total += 2;
    if (nw !== 4) begin bad++; $display("FAIL rnd_writes got=%0d want=4", nw); end
    if (done_cnt !== 1) begin bad++; $display("FAIL rnd_done_pulses got=%0d want=1", done_cnt); end
    for (int k = 0; k < 4; k++) begin
      total += 2;
      if (wd[k] !== 32'hafa8_fffc) begin bad++; $display("FAIL rnd_data%0d got=%h want=afa8fffc", k, wd[k]); end
      if (wa[k] !== 32'h3000 + 32'(4 * k)) begin bad++; $display("FAIL rnd_addr%0d got=%h want=%h", k, wa[k], 32'h3000 + 32'(4 * k)); end
    end
  endtask

  task automatic test_reset_mid;
    int nwb;
    pulse_start(0);
    send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 0, 1, "mid_cmd0");
    send(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0, 0, 1, "mid_cmd1");
    cmd_op = 4'd3; cmd_valid = 1'b1; cmd_last = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    nwb = nw;
    total += 4;
    if (im_we !== 1'b0) begin bad++; $display("FAIL mid_im_we got=%0b want=0", im_we); end
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL mid_ready got=%0b want=0", cmd_ready); end
    if (word_count !== 11'd0) begin bad++; $display("FAIL mid_word_count got=%0d want=0", word_count); end
    if (im_addr !== 32'h3000) begin bad++; $display("FAIL mid_im_addr got=%h want=00003000", im_addr); end
    reset_n = 1'b1;
    wait_cycles(3);
    cmd_valid = 1'b0;
    total++;
    if (nw !== nwb) begin bad++; $display("FAIL mid_no_writes got=%0d want=%0d", nw, nwb); end
    pulse_start(0);
    nw = 0;
    send(4'd4, 5'd0, 5'd5, 5'd0, 16'h1234, 26'h0, 1'b1, 0, 1, "mid_restart");
    wait_cycles(4);
    total += 3;
    if (nw !== 1) begin bad++; $display("FAIL mid_restart_writes got=%0d want=1", nw); end
    if (wa[0] !== 32'h3000) begin bad++; $display("FAIL mid_restart_addr got=%h want=00003000", wa[0]); end
    if (wd[0] !== 32'h3c05_1234) begin bad++; $display("FAIL mid_restart_data got=%h want=3c051234", wd[0]); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_illegal();
    test_full();
    test_random_valid();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
